// File: rtl/tracker_pkg.sv
// Shared types for the tracker record log: entry layout, log depth default,
// and the read-port FSM state encoding.
package tracker_pkg;

  typedef struct packed {
    logic [15:0] packet_id;
    logic [31:0] timestamp;
  } tracker_stats_struct;

  localparam int TRACKER_STATS_W = $bits(tracker_stats_struct);
  localparam int TRACKER_LOG_DEPTH_LOG2 = 10;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } tracker_log_rd_state_e;

endpackage

// File: rtl/tracker_log_buf_ram.sv
// ram_1r1w_sync: one write port, one registered read port, read-first.
// Ports: we_i/waddr_i/wdata_i write, re_i/raddr_i read, rdata_o registered.
module ram_1r1w_sync #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 48
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] rdata_q;

  // Both updates are non-blocking, so a same-address read sees old data.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tracker_log_buf.sv
// Circular tracker record log with overwrite-oldest writes and a
// random-access read port (req/resp handshake); exports wr ptr and count.
module tracker_log_buf
  import tracker_pkg::*;
#(
  parameter int LOG_DEPTH_LOG2 = TRACKER_LOG_DEPTH_LOG2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        log_wr_req_val,
  input  logic [TRACKER_STATS_W-1:0]  log_wr_req_data,
  output logic                        log_wr_req_rdy,
  input  logic                        log_rd_req_val,
  input  logic [LOG_DEPTH_LOG2-1:0]   log_rd_req_addr,
  output logic                        log_rd_req_rdy,
  output logic                        log_rd_resp_val,
  output logic [TRACKER_STATS_W-1:0]  log_rd_resp_data,
  input  logic                        log_rd_resp_rdy,
  input  logic                        log_clear,
  output logic [LOG_DEPTH_LOG2-1:0]   curr_wr_ptr,
  output logic                        has_wrapped,
  output logic [LOG_DEPTH_LOG2:0]     num_entries
);

  localparam logic [LOG_DEPTH_LOG2-1:0] PTR_MAX = '1;
  localparam logic [LOG_DEPTH_LOG2:0] FULL_CNT =
    {1'b1, {LOG_DEPTH_LOG2{1'b0}}};

  logic [LOG_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic                      wrap_q, wrap_d;
  tracker_log_rd_state_e     state_q, state_d;
  tracker_stats_struct       resp_q, resp_d;
  logic [TRACKER_STATS_W-1:0] ram_rdata;
  logic                      wr_fire;
  logic                      rd_en;

  assign log_wr_req_rdy = ~log_clear;
  assign wr_fire = log_wr_req_val & log_wr_req_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wrap_d   = wrap_q;
    if (log_clear) begin
      wr_ptr_d = '0;
      wrap_d   = 1'b0;
    end else if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == PTR_MAX) wrap_d = 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    resp_d          = resp_q;
    rd_en           = 1'b0;
    log_rd_req_rdy  = 1'b0;
    log_rd_resp_val = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        log_rd_req_rdy = 1'b1;
        if (log_rd_req_val) begin
          rd_en   = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        resp_d  = tracker_stats_struct'(ram_rdata);
        state_d = RD_RESP;
      end
      RD_RESP: begin
        log_rd_resp_val = 1'b1;
        if (log_rd_resp_rdy) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      wrap_q   <= 1'b0;
      state_q  <= RD_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wrap_q   <= wrap_d;
      state_q  <= state_d;
    end
  end

  // Response data needs no reset; it is only observed in RD_RESP.
  always_ff @(posedge clk) begin
    resp_q <= resp_d;
  end

  ram_1r1w_sync #(
    .DEPTH_LOG2 (LOG_DEPTH_LOG2),
    .WIDTH      (TRACKER_STATS_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (log_wr_req_data),
    .re_i    (rd_en),
    .raddr_i (log_rd_req_addr),
    .rdata_o (ram_rdata)
  );

  assign log_rd_resp_data = resp_q;
  assign curr_wr_ptr      = wr_ptr_q;
  assign has_wrapped      = wrap_q;
  assign num_entries      = wrap_q ? FULL_CNT : {1'b0, wr_ptr_q};

endmodule

// File: tb/tb_tracker_log_buf.sv
// Randomised + directed bench for tracker_log_buf (depth 4) with a
// queue-style reference log and a separate response monitor.
module tb_tracker_log_buf;
  import tracker_pkg::*;

  localparam int LW = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic log_wr_req_val = 1'b0;
  tracker_stats_struct log_wr_req_data = '0;
  logic log_wr_req_rdy;
  logic log_rd_req_val = 1'b0;
  logic [LW-1:0] log_rd_req_addr = '0;
  logic log_rd_req_rdy;
  logic log_rd_resp_val;
  logic [TRACKER_STATS_W-1:0] log_rd_resp_data;
  logic log_rd_resp_rdy = 1'b1;
  logic log_clear = 1'b0;
  logic [LW-1:0] curr_wr_ptr;
  logic has_wrapped;
  logic [LW:0] num_entries;

  tracker_log_buf #(.LOG_DEPTH_LOG2(LW)) dut (
    .clk              (clk),
    .rst              (rst),
    .log_wr_req_val   (log_wr_req_val),
    .log_wr_req_data  (log_wr_req_data),
    .log_wr_req_rdy   (log_wr_req_rdy),
    .log_rd_req_val   (log_rd_req_val),
    .log_rd_req_addr  (log_rd_req_addr),
    .log_rd_req_rdy   (log_rd_req_rdy),
    .log_rd_resp_val  (log_rd_resp_val),
    .log_rd_resp_data (log_rd_resp_data),
    .log_rd_resp_rdy  (log_rd_resp_rdy),
    .log_clear        (log_clear),
    .curr_wr_ptr      (curr_wr_ptr),
    .has_wrapped      (has_wrapped),
    .num_entries      (num_entries)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference log: contents, fill pointer, wrapped flag.
  tracker_stats_struct m_mem [DEPTH];
  bit m_known [DEPTH];
  int m_ptr = 0;
  bit m_wrap = 1'b0;

  // Expected responses: written by stimulus, consumed by monitor.
  tracker_stats_struct exp_d [256];
  int exp_c [256];
  int n_iss = 0;
  int n_done = 0;
  bit armed = 1'b0;
  bit lat_done = 1'b0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  function automatic tracker_stats_struct mk(int pid, int ts);
    tracker_stats_struct s;
    s.packet_id = 16'(pid);
    s.timestamp = 32'(ts);
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      n_done = n_iss;
      lat_done = 1'b0;
    end else if (armed && log_rd_resp_val !== 1'b0) begin
      if (n_done == n_iss) begin
        chk("unexpected_resp", 64'(log_rd_resp_val), 64'd0);
      end else begin
        if (!lat_done) begin
          chk("latency", 64'(cyc), 64'(exp_c[n_done % 256] + 2));
          lat_done = 1'b1;
        end
        chk("resp_data", 64'(log_rd_resp_data), 64'(exp_d[n_done % 256]));
        if (log_rd_resp_rdy) begin
          n_done++;
          lat_done = 1'b0;
        end
      end
    end
  end

  task automatic step(input bit wv, input tracker_stats_struct wd,
                      input bit rv, input logic [LW-1:0] ra,
                      input bit clr, input bit rr);
    bit erd;
    log_wr_req_val = wv;
    log_wr_req_data = wd;
    log_rd_req_val = rv;
    log_rd_req_addr = ra;
    log_clear = clr;
    log_rd_resp_rdy = rr;
    #1;
    erd = (n_iss == n_done);
    chk("wr_req_rdy", 64'(log_wr_req_rdy), 64'(!clr));
    chk("rd_req_rdy", 64'(log_rd_req_rdy), 64'(erd));
    if (!rst) begin
      if (rv && erd) begin
        exp_d[n_iss % 256] = m_mem[ra];
        exp_c[n_iss % 256] = cyc;
        n_iss++;
      end
      if (clr) begin
        m_ptr = 0;
        m_wrap = 1'b0;
      end else if (wv) begin
        m_mem[m_ptr] = wd;
        m_known[m_ptr] = 1'b1;
        if (m_ptr == DEPTH - 1) m_wrap = 1'b1;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end else begin
      m_ptr = 0;
      m_wrap = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("wr_ptr", 64'(curr_wr_ptr), 64'(m_ptr));
    chk("has_wrapped", 64'(has_wrapped), 64'(m_wrap));
    chk("num_entries", 64'(num_entries), 64'(m_wrap ? DEPTH : m_ptr));
    log_wr_req_val = 1'b0;
    log_rd_req_val = 1'b0;
    log_clear = 1'b0;
  endtask

  task automatic idle(input bit rr);
    step(1'b0, '0, 1'b0, '0, 1'b0, rr);
  endtask

  task automatic wr(input int pid, input int ts);
    step(1'b1, mk(pid, ts), 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [LW-1:0] a, input bit rr);
    step(1'b0, '0, 1'b1, a, 1'b0, rr);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n_iss != n_done && n < 40) begin
      idle(1'b1);
      n++;
    end
    chk("drain_timeout", 64'(n_iss != n_done), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    armed = 1'b1;
    chk("rst_wr_ptr", 64'(curr_wr_ptr), 64'd0);
    chk("rst_wrapped", 64'(has_wrapped), 64'd0);
    chk("rst_num", 64'(num_entries), 64'd0);
    chk("rst_resp_val", 64'(log_rd_resp_val), 64'd0);
    chk("rst_rd_rdy", 64'(log_rd_req_rdy), 64'd1);
    chk("rst_wr_rdy", 64'(log_wr_req_rdy), 64'd1);

    wr(1, 10);
    wr(2, 11);
    rd(2'd1, 1'b1);
    wait_idle();

    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) wr(i, 20 + i);
    rd(2'd0, 1'b1);
    wait_idle();
    rd(2'd1, 1'b1);
    wait_idle();

    rd(2'd3, 1'b0);
    repeat (7) idle(1'b0);
    wait_idle();
    idle(1'b1);

    wr(6, 30);
    step(1'b1, mk(9, 31), 1'b1, 2'd2, 1'b0, 1'b1);
    wait_idle();
    rd(2'd2, 1'b1);
    wait_idle();

    step(1'b1, mk(8, 40), 1'b0, '0, 1'b1, 1'b1);
    wr(7, 41);
    rd(2'd0, 1'b1);
    wait_idle();

    rd(2'd0, 1'b1);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    repeat (4) idle(1'b1);

    for (int k = 0; k < 400; k++) begin
      tracker_stats_struct d;
      bit wv, rv, clr, rr;
      logic [LW-1:0] ra;
      d.packet_id = 16'($urandom);
      d.timestamp = $urandom;
      wv = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 4);
      ra = LW'($urandom_range(0, DEPTH - 1));
      if (!m_known[ra]) rv = 1'b0;
      clr = ($urandom_range(0, 19) == 0);
      rr = ($urandom_range(0, 9) < 7);
      step(wv, d, rv, ra, clr, rr);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tracker_log_buf.md
Name: tracker_log_buf

Overview:
- Consumes tracker record entries (tracker_stats_struct: packet_id + timestamp) from the tracker record datapath and its control logic.
- Stores each entry in a circular on-chip log; when full, the oldest entry is overwritten.
- Provides a random-access read port with a valid/ready response handshake, used by the log-dump NoC reader.
- Exports the write pointer and entry count so software can locate the oldest and newest entries.

Parameters:
- LOG_DEPTH_LOG2, 10: log2 of the number of log entries (depth = 2**LOG_DEPTH_LOG2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- log_wr_req_val  in  1  record entry valid
- log_wr_req_data  in  TRACKER_STATS_W  entry (tracker_stats_struct)
- log_wr_req_rdy  out  1  buffer accepts entry
- log_rd_req_val  in  1  read request valid
- log_rd_req_addr  in  LOG_DEPTH_LOG2  entry index
- log_rd_req_rdy  out  1  read request accepted
- log_rd_resp_val  out  1  read data valid
- log_rd_resp_data  out  TRACKER_STATS_W  read entry
- log_rd_resp_rdy  in  1  consumer takes data
- log_clear  in  1  one-cycle pulse: empty the log
- curr_wr_ptr  out  LOG_DEPTH_LOG2  index of the next slot to write
- has_wrapped  out  1  log has been filled at least once
- num_entries  out  LOG_DEPTH_LOG2+1  valid entry count

Behaviour:
- Reset:
  - curr_wr_ptr=0, has_wrapped=0.
  - log_rd_resp_val=0, read FSM in RD_IDLE.
  - log_rd_req_rdy=1 and log_wr_req_rdy=1 once reset deasserts.
  - Memory contents are not cleared.
- Write path:
  - log_wr_req_rdy = ~log_clear. The log never back-pressures for fullness.
  - On val&rdy: mem[curr_wr_ptr] <= data, curr_wr_ptr <= curr_wr_ptr+1 (mod depth).
  - When curr_wr_ptr is at depth-1 and a write fires, curr_wr_ptr wraps to 0 and has_wrapped <= 1 (sticky).
- num_entries = has_wrapped ? 2**LOG_DEPTH_LOG2 : curr_wr_ptr. Combinational from registers.
- Clear:
  - log_clear sets curr_wr_ptr<=0 and has_wrapped<=0 in one cycle.
  - A write presented in the same cycle is refused (rdy=0), so clear wins.
  - Clear does not affect an in-flight read.
- Read FSM (states RD_IDLE, RD_WAIT, RD_RESP):
  - RD_IDLE: log_rd_req_rdy=1. On val, drive the RAM read address, latch nothing else, go to RD_WAIT.
  - RD_WAIT: the RAM produces data (1-cycle sync read). Capture it into the response register and go to RD_RESP.
  - RD_RESP: log_rd_resp_val=1, data held stable. On log_rd_resp_rdy, go to RD_IDLE.
  - Minimum request-to-response latency: 2 cycles. Maximum throughput: one read per 3 cycles. No pipelining, one outstanding read.
  - log_rd_req_rdy=0 in RD_WAIT and RD_RESP.
- Read/write collision: a RAM read issued in the same cycle as a write to the same address returns the OLD content (read-first).
- A read of an index >= num_entries is legal and returns stale or uninitialised memory. Software uses num_entries to bound reads.
- Reset mid-read: the FSM returns to RD_IDLE and log_rd_resp_val drops the next cycle. The pending response is discarded.
- Writes and reads are fully independent and can fire in the same cycle.

Decomposition:
- tracker_pkg holds:
  - tracker_stats_struct
  - TRACKER_STATS_W ($bits of the struct)
  - TRACKER_LOG_DEPTH_LOG2 default
  - the read FSM state enum tracker_log_rd_state_e
- One sub-module, ram_1r1w_sync:
  - parameters DEPTH_LOG2, WIDTH.
  - one write port, one registered read port, read-first semantics.
- All pointer, FSM, and handshake logic lives in tracker_log_buf.

Test Plan (LOG_DEPTH_LOG2=2, depth 4):
- After reset, write entries {pid=1,ts=10}, {pid=2,ts=11} back-to-back -> curr_wr_ptr=2, num_entries=2, has_wrapped=0. Read addr 1 -> resp {2,11} exactly 2 cycles after request acceptance.
- Write 5 entries pid=1..5 -> curr_wr_ptr=1, has_wrapped=1, num_entries=4. Read addr 0 -> pid=5; read addr 1 -> pid=2.
- Hold log_rd_resp_rdy=0 for 5 cycles in RD_RESP -> resp_val stays 1, data stable, log_rd_req_rdy=0. Release -> one transfer, then rdy=1.
- Issue a read of addr 2 and a write of pid=9 to addr 2 in the same cycle (old content pid=3) -> response pid=3. A later read of addr 2 -> pid=9.
- Assert log_clear together with log_wr_req_val -> write not accepted, curr_wr_ptr=0, has_wrapped=0, num_entries=0. Next-cycle write lands at addr 0.
- Assert rst while in RD_WAIT -> no response is ever presented (resp_val=0). log_rd_req_rdy=1 on the first cycle after rst deasserts.
